// File: rtl/game_controller_n.sv
// game_controller_n: sequences login request, game start, timed play and
// stop/replay for NUM_BTN debounced buttons. bIn[0] doubles as the control
// button; every control decision is taken on its rising edge, never its level.
module game_controller_n #(
    parameter int NUM_BTN       = 3,
    parameter int GAME_CYCLES   = 1000,
    parameter int LOGIN_TIMEOUT = 500,
    parameter int TIME_W        = 16,
    parameter int RND_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] bIn,
    input  logic               userLog,
    input  logic               stopIn,
    output logic               userLoad,
    output logic               startGame,
    output logic [NUM_BTN-1:0] bOut,
    output logic [NUM_BTN-1:0] bPulse,
    output logic               gameOver,
    output logic               timedOut,
    output logic [TIME_W-1:0]  timeLeft,
    output logic [RND_W-1:0]   roundCnt
);

    localparam logic [1:0] WAIT_USER  = 2'd0;
    localparam logic [1:0] WAIT_START = 2'd1;
    localparam logic [1:0] PLAY       = 2'd2;
    localparam logic [1:0] STOP       = 2'd3;

    localparam logic [TIME_W-1:0] GAME_T  = TIME_W'(GAME_CYCLES);
    localparam logic [TIME_W-1:0] LOGIN_T = TIME_W'(LOGIN_TIMEOUT);
    localparam logic [TIME_W-1:0] ONE_T   = TIME_W'(1);

    logic [1:0]         state_q, state_d;
    logic [NUM_BTN-1:0] bprev_q;
    logic [NUM_BTN-1:0] rise;
    logic               userload_q, userload_d;
    logic               startgame_q, startgame_d;
    logic [NUM_BTN-1:0] bout_q, bout_d;
    logic [NUM_BTN-1:0] bpulse_q, bpulse_d;
    logic               gameover_q, gameover_d;
    logic               timedout_q, timedout_d;
    logic [TIME_W-1:0]  timeleft_q, timeleft_d;
    logic [TIME_W-1:0]  logintmr_q, logintmr_d;
    logic [RND_W-1:0]   roundcnt_q, roundcnt_d;

    // Completed-game counter sticks at all ones instead of wrapping.
    function automatic logic [RND_W-1:0] sat_inc(input logic [RND_W-1:0] v);
        return (v == {RND_W{1'b1}}) ? v : v + RND_W'(1);
    endfunction

    // Next-state and output decode; pulses default low, levels default to hold.
    always_comb begin
        rise        = bIn & ~bprev_q;
        state_d     = state_q;
        userload_d  = 1'b0;
        startgame_d = startgame_q;
        bout_d      = '0;
        bpulse_d    = '0;
        gameover_d  = 1'b0;
        timedout_d  = timedout_q;
        timeleft_d  = timeleft_q;
        logintmr_d  = logintmr_q;
        roundcnt_d  = roundcnt_q;
        case (state_q)
            WAIT_USER: begin
                if (rise[0]) begin
                    userload_d = 1'b1;
                    logintmr_d = '0;
                    state_d    = WAIT_START;
                end
            end
            WAIT_START: begin
                if (userLog && rise[0]) begin
                    startgame_d = 1'b1;
                    timeleft_d  = GAME_T;
                    logintmr_d  = '0;
                    state_d     = PLAY;
                end else if (!userLog) begin
                    logintmr_d = logintmr_q + ONE_T;
                    if ((LOGIN_TIMEOUT != 0) && (logintmr_d == LOGIN_T)) begin
                        state_d = WAIT_USER;
                    end
                end else begin
                    logintmr_d = '0;
                end
            end
            PLAY: begin
                // An external stop wins over an expiring timer in the same cycle.
                if (stopIn) begin
                    state_d     = STOP;
                    timedout_d  = 1'b0;
                    startgame_d = 1'b0;
                    gameover_d  = 1'b1;
                    roundcnt_d  = sat_inc(roundcnt_q);
                end else if ((GAME_CYCLES != 0) && (timeleft_q == ONE_T)) begin
                    state_d     = STOP;
                    timeleft_d  = '0;
                    timedout_d  = 1'b1;
                    startgame_d = 1'b0;
                    gameover_d  = 1'b1;
                    roundcnt_d  = sat_inc(roundcnt_q);
                end else begin
                    bout_d   = bIn;
                    bpulse_d = rise;
                    if (GAME_CYCLES != 0) begin
                        timeleft_d = timeleft_q - ONE_T;
                    end
                end
            end
            STOP: begin
                // Replay goes straight back to WAIT_START; the login is kept.
                if (rise[0]) begin
                    timedout_d = 1'b0;
                    logintmr_d = '0;
                    state_d    = WAIT_START;
                end
            end
            default: begin
                state_d     = WAIT_USER;
                startgame_d = 1'b0;
                timedout_d  = 1'b0;
                timeleft_d  = '0;
                logintmr_d  = '0;
                roundcnt_d  = '0;
            end
        endcase
    end

    // State registers; button history keeps sampling through reset so a
    // button held across reset release is not mistaken for a fresh press.
    always_ff @(posedge clk) begin
        bprev_q <= bIn;
        if (!rst) begin
            state_q     <= WAIT_USER;
            userload_q  <= 1'b0;
            startgame_q <= 1'b0;
            bout_q      <= '0;
            bpulse_q    <= '0;
            gameover_q  <= 1'b0;
            timedout_q  <= 1'b0;
            timeleft_q  <= '0;
            logintmr_q  <= '0;
            roundcnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            userload_q  <= userload_d;
            startgame_q <= startgame_d;
            bout_q      <= bout_d;
            bpulse_q    <= bpulse_d;
            gameover_q  <= gameover_d;
            timedout_q  <= timedout_d;
            timeleft_q  <= timeleft_d;
            logintmr_q  <= logintmr_d;
            roundcnt_q  <= roundcnt_d;
        end
    end

    assign userLoad  = userload_q;
    assign startGame = startgame_q;
    assign bOut      = bout_q;
    assign bPulse    = bpulse_q;
    assign gameOver  = gameover_q;
    assign timedOut  = timedout_q;
    assign timeLeft  = timeleft_q;
    assign roundCnt  = roundcnt_q;

endmodule

// File: tb/tb_game_controller_n.sv
// Directed bench for game_controller_n: reset, login, login timeout, play
// buttons, game timeout, stop-vs-timeout priority, replay, counter saturation
// and reset during play.
module tb_game_controller_n;

    logic        clk;
    logic        rst;
    logic [2:0]  bIn;
    logic        userLog;
    logic        stopIn;
    logic        userLoad;
    logic        startGame;
    logic [2:0]  bOut;
    logic [2:0]  bPulse;
    logic        gameOver;
    logic        timedOut;
    logic [15:0] timeLeft;
    logic [1:0]  roundCnt;

    int vectors;
    int miscompares;

    game_controller_n #(
        .NUM_BTN      (3),
        .GAME_CYCLES  (10),
        .LOGIN_TIMEOUT(5),
        .TIME_W       (16),
        .RND_W        (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bIn      (bIn),
        .userLog  (userLog),
        .stopIn   (stopIn),
        .userLoad (userLoad),
        .startGame(startGame),
        .bOut     (bOut),
        .bPulse   (bPulse),
        .gameOver (gameOver),
        .timedOut (timedOut),
        .timeLeft (timeLeft),
        .roundCnt (roundCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From STOP: replay into PLAY, stop immediately, check the round count.
    task automatic replay_and_stop(input logic [1:0] exp_rnd);
        bIn = 3'b000; step();
        bIn = 3'b001; step();
        bIn = 3'b000; step();
        bIn = 3'b001; step();
        check("replay_start", 32'(startGame), 32'd1);
        stopIn = 1'b1; step();
        stopIn = 1'b0;
        check("replay_gameover", 32'(gameOver), 32'd1);
        check("replay_roundcnt", 32'(roundCnt), 32'(exp_rnd));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b0;
        bIn     = 3'b111;
        userLog = 1'b0;
        stopIn  = 1'b0;
        step();
        step();
        check("rst_userLoad", 32'(userLoad), 32'd0);
        check("rst_startGame", 32'(startGame), 32'd0);
        check("rst_bOut", 32'(bOut), 32'd0);
        check("rst_bPulse", 32'(bPulse), 32'd0);
        check("rst_gameOver", 32'(gameOver), 32'd0);
        check("rst_timedOut", 32'(timedOut), 32'd0);
        check("rst_timeLeft", 32'(timeLeft), 32'd0);
        check("rst_roundCnt", 32'(roundCnt), 32'd0);

        // Held button across reset release is not a press.
        rst = 1'b1;
        step();
        check("held_no_load0", 32'(userLoad), 32'd0);
        step();
        check("held_no_load1", 32'(userLoad), 32'd0);
        bIn = 3'b000; step();
        check("release_no_load", 32'(userLoad), 32'd0);
        bIn = 3'b001; step();
        check("userLoad_pulse", 32'(userLoad), 32'd1);
        step();
        check("userLoad_one_cycle", 32'(userLoad), 32'd0);

        // Login timeout (5 cycles). A press on the 5th cycle is still in WAIT_START.
        bIn = 3'b000; step();
        step();
        step();
        bIn = 3'b001; step();
        check("timeout_not_early", 32'(userLoad), 32'd0);
        bIn = 3'b000; step();
        bIn = 3'b001; step();
        check("after_timeout_load", 32'(userLoad), 32'd1);
        // Second round: a press on the 6th cycle must already see WAIT_USER.
        bIn = 3'b000;
        step(); step(); step(); step(); step();
        bIn = 3'b001; step();
        check("timeout_not_late", 32'(userLoad), 32'd1);

        // Login and start.
        userLog = 1'b1;
        bIn = 3'b000; step();
        check("wait_no_start", 32'(startGame), 32'd0);
        bIn = 3'b001; step();
        check("start_game", 32'(startGame), 32'd1);
        check("start_timeLeft", 32'(timeLeft), 32'd10);
        step();
        check("held_bOut", 32'(bOut), 32'd1);
        check("held_no_bPulse0", 32'(bPulse), 32'd0);
        check("tl_9", 32'(timeLeft), 32'd9);

        // Button 1 pressed for three cycles.
        bIn = 3'b010; step();
        check("b1_bOut_c1", 32'(bOut), 32'b010);
        check("b1_bPulse_c1", 32'(bPulse), 32'b010);
        step();
        check("b1_bOut_c2", 32'(bOut), 32'b010);
        check("b1_bPulse_c2", 32'(bPulse), 32'b000);
        step();
        check("b1_bOut_c3", 32'(bOut), 32'b010);
        bIn = 3'b000; step();
        check("b1_bOut_rel", 32'(bOut), 32'b000);
        check("tl_5", 32'(timeLeft), 32'd5);
        step(); step(); step(); step();
        check("tl_1", 32'(timeLeft), 32'd1);
        check("tl_1_startGame", 32'(startGame), 32'd1);
        step();
        check("to_gameOver", 32'(gameOver), 32'd1);
        check("to_timedOut", 32'(timedOut), 32'd1);
        check("to_startGame", 32'(startGame), 32'd0);
        check("to_timeLeft", 32'(timeLeft), 32'd0);
        check("to_roundCnt", 32'(roundCnt), 32'd1);
        step();
        check("to_gameOver_once", 32'(gameOver), 32'd0);
        check("to_timedOut_hold", 32'(timedOut), 32'd1);
        check("stop_bOut", 32'(bOut), 32'd0);

        // Replay, then stop in the same cycle the timer expires.
        bIn = 3'b001; step();
        check("replay_timedOut_clr", 32'(timedOut), 32'd0);
        check("replay_wait_start", 32'(startGame), 32'd0);
        bIn = 3'b000; step();
        bIn = 3'b001; step();
        check("g2_start", 32'(startGame), 32'd1);
        for (int i = 0; i < 9; i++) step();
        check("g2_tl_1", 32'(timeLeft), 32'd1);
        stopIn = 1'b1; step();
        stopIn = 1'b0;
        check("g2_gameOver", 32'(gameOver), 32'd1);
        check("g2_stop_wins", 32'(timedOut), 32'd0);
        check("g2_timeLeft_hold", 32'(timeLeft), 32'd1);
        check("g2_roundCnt", 32'(roundCnt), 32'd2);
        step();
        check("g2_gameOver_off", 32'(gameOver), 32'd0);
        step();
        check("g2_gameOver_once", 32'(gameOver), 32'd0);

        // Saturation of the 2-bit round counter.
        replay_and_stop(2'd3);
        replay_and_stop(2'd3);
        replay_and_stop(2'd3);

        // Reset during PLAY aborts without gameOver.
        bIn = 3'b000; step();
        bIn = 3'b001; step();
        bIn = 3'b000; step();
        bIn = 3'b001; step();
        step();
        check("pre_rst_startGame", 32'(startGame), 32'd1);
        rst = 1'b0; step();
        check("mid_rst_startGame", 32'(startGame), 32'd0);
        check("mid_rst_gameOver", 32'(gameOver), 32'd0);
        check("mid_rst_roundCnt", 32'(roundCnt), 32'd0);
        rst = 1'b1; step();
        check("post_rst_gameOver", 32'(gameOver), 32'd0);
        check("post_rst_startGame", 32'(startGame), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
